// File: rtl/mac_pkg.sv
// Shared defaults and the signed width-reduction helper for the MAC array.
package mac_pkg;

  localparam int LANES_DEF   = 4;
  localparam int BW_DEF      = 4;
  localparam int PSUM_BW_DEF = 16;

  // Reduce v to a signed w-bit range, returned sign-extended to 64 bits.
  // Any difference between input and result means the value did not fit.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int w,
                                                   input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] res;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    res = (v <<< (64 - w)) >>> (64 - w);
    if (sat && (v > hi)) begin
      res = hi;
    end else if (sat && (v < lo)) begin
      res = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// One multiply lane: mode-dependent activation extension and a registered
// exact signed product of width 2*BW+1.
module mac_lane_mult
  import mac_pkg::*;
#(
  parameter int BW = BW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic                act_signed_i,
  input  logic [BW-1:0]       a_i,
  input  logic [BW-1:0]       b_i,
  output logic signed [2*BW:0] prod_o
);

  logic signed [2*BW:0] a_ext;
  logic signed [2*BW:0] b_ext;
  logic signed [2*BW:0] prod_d;
  logic signed [2*BW:0] prod_q;

  assign a_ext  = {{(BW+1){act_signed_i & a_i[BW-1]}}, a_i};
  assign b_ext  = {{(BW+1){b_i[BW-1]}}, b_i};
  // |a| <= 2^BW and |b| <= 2^(BW-1), so the product always fits exactly.
  assign prod_d = a_ext * b_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
    end else if (en_i) begin
      prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/mac_array_acc.sv
// N-lane dot-product engine: registered lane products, then adder tree plus
// framed accumulation with optional saturation and a sticky overflow flag.
module mac_array_acc
  import mac_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int bw      = BW_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter bit SAT     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  act_signed,
  input  logic [LANES*bw-1:0]   a,
  input  logic [LANES*bw-1:0]   b,
  input  logic [psum_bw-1:0]    c_in,
  output logic [psum_bw-1:0]    out,
  output logic                  out_valid,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int PW  = 2*bw + 1;
  localparam int LOG = $clog2(LANES);
  localparam int SW  = PW + LOG;

  logic signed [PW-1:0] prod [LANES];
  logic signed [SW-1:0] tree_sum;

  logic                      s1_valid_q, s1_valid_d;
  logic                      s1_first_q, s1_first_d;
  logic                      s1_last_q,  s1_last_d;
  logic signed [psum_bw-1:0] s1_cin_q,   s1_cin_d;
  logic                      open_q,     open_d;
  logic signed [psum_bw-1:0] acc_q,      acc_d;
  logic                      ovf_q,      ovf_d;
  logic        [psum_bw-1:0] out_q,      out_d;
  logic                      out_ovf_q,  out_ovf_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [63:0] base_ext;
  logic signed [63:0] acc_wide;
  logic signed [63:0] acc_red;
  logic               beat_ovf;

  genvar gi, gj;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      mac_lane_mult #(.BW(bw)) u_lane (
        .clk          (clk),
        .reset        (reset),
        .en_i         (in_valid),
        .act_signed_i (act_signed),
        .a_i          (a[gi*bw +: bw]),
        .b_i          (b[gi*bw +: bw]),
        .prod_o       (prod[gi])
      );
    end

    // Pairwise tree; level gi holds LANES>>gi partial sums.
    for (gi = 0; gi <= LOG; gi++) begin : g_lvl
      logic signed [SW-1:0] node [LANES >> gi];
      for (gj = 0; gj < (LANES >> gi); gj++) begin : g_node
        if (gi == 0) begin : g_leaf
          assign node[gj] = SW'(prod[gj]);
        end else begin : g_sum
          assign node[gj] = g_lvl[gi-1].node[2*gj] + g_lvl[gi-1].node[2*gj+1];
        end
      end
    end
  endgenerate

  assign tree_sum = g_lvl[LOG].node[0];

  always_comb begin
    s1_valid_d = in_valid;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_cin_d   = s1_cin_q;
    open_d     = open_q;
    if (in_valid) begin
      s1_first_d = in_first;
      s1_last_d  = in_last;
      s1_cin_d   = c_in;
      if (in_last) begin
        open_d = 1'b0;
      end else if (in_first) begin
        open_d = 1'b1;
      end
    end
  end

  always_comb begin
    base_ext    = s1_first_q ? 64'(s1_cin_q) : 64'(acc_q);
    acc_wide    = base_ext + 64'(tree_sum);
    acc_red     = sat_clamp(acc_wide, psum_bw, SAT);
    beat_ovf    = (acc_red != acc_wide);
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_d       = out_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = 1'b0;
    if (s1_valid_q) begin
      acc_d = acc_red[psum_bw-1:0];
      ovf_d = (s1_first_q ? 1'b0 : ovf_q) | beat_ovf;
      if (s1_last_q) begin
        out_d       = acc_red[psum_bw-1:0];
        out_ovf_d   = ovf_d;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_cin_q    <= '0;
      open_q      <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_q       <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_cin_q    <= s1_cin_d;
      open_q      <= open_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_q       <= out_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = open_q | s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_mac_array_acc.sv
// Randomised and directed bench: three configurations (16-bit wrap, 8-bit
// saturate, 8-bit wrap) fed the same beats and checked against a dot-product model.
module tb_mac_array_acc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, act_signed = 1'b0;
  logic [15:0] a = '0, b = '0, c_in = '0;

  logic [15:0] out0;
  logic [7:0]  out1, out2;
  logic        ov0, ov1, ov2, of0, of1, of2, bz0, bz1, bz2;

  always #5 clk = ~clk;

  mac_array_acc u_wrap16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .act_signed(act_signed), .a(a), .b(b), .c_in(c_in),
    .out(out0), .out_valid(ov0), .out_ovf(of0), .busy(bz0));

  mac_array_acc #(.psum_bw(8), .SAT(1'b1)) u_sat8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .act_signed(act_signed), .a(a), .b(b), .c_in(c_in[7:0]),
    .out(out1), .out_valid(ov1), .out_ovf(of1), .busy(bz1));

  mac_array_acc #(.psum_bw(8), .SAT(1'b0)) u_wrap8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .act_signed(act_signed), .a(a), .b(b), .c_in(c_in[7:0]),
    .out(out2), .out_valid(ov2), .out_ovf(of2), .busy(bz2));

  typedef struct packed {
    int               due;
    logic [2:0][15:0] val;
    logic [2:0]       ovf;
  } exp_t;

  exp_t        exp_q[$];
  longint      m_acc[3];
  bit          m_ovf[3];
  bit          m_open;
  logic [15:0] last_out[3];
  int          edge_n;
  int          checks;
  int          errors;

  task automatic check(input string tag, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, expv, edge_n);
    end
  endtask

  function automatic int width_of(input int k);
    return (k == 0) ? 16 : 8;
  endfunction

  // Signed reduction of v into w bits; o reports that v was out of range.
  function automatic longint reduce(input longint v, input int w, input bit sat, output bit o);
    longint hi, lo, m;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    o  = (v > hi) || (v < lo);
    if (!o) return v;
    if (sat) return (v > hi) ? hi : lo;
    m = v & ((longint'(1) << w) - 1);
    if (m > hi) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic longint dot(input logic [15:0] av, input logic [15:0] bv, input bit sgn);
    longint s, x, y;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      x = longint'(av[i*4 +: 4]);
      y = longint'(bv[i*4 +: 4]);
      if (sgn && x >= 8) x = x - 16;
      if (y >= 8) y = y - 16;
      s = s + x * y;
    end
    return s;
  endfunction

  task automatic model_beat(input bit f, input bit l, input bit s,
                            input logic [15:0] av, input logic [15:0] bv, input logic [15:0] cv);
    longint d, base, r;
    bit     o, dummy;
    exp_t   e;
    d = dot(av, bv, s);
    e = '0;
    e.due = edge_n + 1;
    for (int k = 0; k < 3; k++) begin
      base     = f ? reduce(longint'(cv), width_of(k), 1'b0, dummy) : m_acc[k];
      r        = reduce(base + d, width_of(k), (k == 1), o);
      m_ovf[k] = (f ? 1'b0 : m_ovf[k]) | o;
      m_acc[k] = r;
      e.val[k] = 16'(r);
      e.ovf[k] = m_ovf[k];
    end
    if (l) begin
      m_open = 1'b0;
      exp_q.push_back(e);
    end else if (f) begin
      m_open = 1'b1;
    end
  endtask

  task automatic check_cycle(input bit accepted);
    bit          due;
    exp_t        e;
    logic [15:0] mask;
    logic [15:0] got_out[3];
    logic        got_v[3];
    logic        got_o[3];
    logic        got_b[3];
    got_out = '{out0, {8'h00, out1}, {8'h00, out2}};
    got_v   = '{ov0, ov1, ov2};
    got_o   = '{of0, of1, of2};
    got_b   = '{bz0, bz1, bz2};
    due = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
    e = '0;
    if (due) e = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      mask = (k == 0) ? 16'hFFFF : 16'h00FF;
      check($sformatf("out_valid%0d", k), longint'(got_v[k]), longint'(due));
      check($sformatf("busy%0d", k), longint'(got_b[k]), longint'(m_open | accepted | due));
      if (due) begin
        last_out[k] = e.val[k] & mask;
        check($sformatf("ovf%0d", k), longint'(got_o[k]), longint'(e.ovf[k]));
      end
      check($sformatf("out%0d", k), longint'(got_out[k]), longint'(last_out[k]));
    end
  endtask

  task automatic step(input bit v, input bit f, input bit l, input bit s,
                      input logic [15:0] av, input logic [15:0] bv, input logic [15:0] cv);
    in_valid = v; in_first = f; in_last = l; act_signed = s;
    a = av; b = bv; c_in = cv;
    @(posedge clk);
    edge_n++;
    if (v) model_beat(f, l, s, av, bv, cv);
    @(negedge clk);
    check_cycle(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    #1;
    check("rst_out0", longint'(out0), 0);
    check("rst_out1", longint'(out1), 0);
    check("rst_valid", longint'({ov0, ov1, ov2}), 0);
    check("rst_ovf", longint'({of0, of1, of2}), 0);
    check("rst_busy", longint'({bz0, bz1, bz2}), 0);
    exp_q.delete();
    m_open = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0; m_ovf[k] = 1'b0; last_out[k] = '0;
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; edge_n = 0;
    #1;
    do_reset();

    // Single beat: 1-2+6-8 + 10 = 7, out_valid after the next edge.
    step(1, 1, 1, 0, 16'h4321, 16'hE2F1, 16'd10);
    idle(1);
    check("tp1_out", longint'(out0), 16'h0007);
    idle(1);

    // Five beats of -480 each, then the same with bubbles in between.
    for (int i = 0; i < 5; i++) step(1, (i == 0), (i == 4), 0, 16'hFFFF, 16'h8888, 16'h0);
    idle(1);
    check("tp2_out", longint'(out0), 16'hF6A0);
    for (int i = 0; i < 5; i++) begin
      step(1, (i == 0), (i == 4), 0, 16'hFFFF, 16'h8888, 16'h0);
      idle(i % 3);
    end
    idle(2);

    // Activation mode, and 8-bit saturate/wrap of 420.
    step(1, 1, 1, 1, 16'hFFFF, 16'h7777, 16'h0);
    idle(1);
    check("tp3_signed", longint'(out0), 16'hFFE4);
    step(1, 1, 1, 0, 16'hFFFF, 16'h7777, 16'h0);
    idle(1);
    check("tp3_unsigned", longint'(out0), 16'h01A4);
    check("tp4_sat", longint'(out1), 8'h7F);
    check("tp4_wrap", longint'(out2), 8'hA4);
    check("tp4_ovf", longint'({of1, of2}), 2'b11);
    step(1, 1, 1, 0, 16'h0001, 16'h0001, 16'h0);
    idle(1);
    check("tp4_clear", longint'({of0, of1, of2}), 0);

    // Abort by a new first, then a reset in the middle of a frame.
    step(1, 1, 0, 0, 16'h1234, 16'h1111, 16'd50);
    step(1, 0, 0, 0, 16'h4321, 16'h2222, 16'd0);
    step(1, 1, 1, 0, 16'h0001, 16'h0003, 16'd0);
    idle(1);
    check("tp5_abort", longint'(out0), 16'h0003);
    step(1, 1, 0, 0, 16'h5555, 16'h3333, 16'd7);
    step(1, 0, 0, 0, 16'h5555, 16'h3333, 16'd0);
    do_reset();
    idle(3);

    // Back-to-back frames: 1*2+1 + 1*2 = 5, then 1*-2 = -2.
    step(1, 1, 0, 0, 16'h0001, 16'h0002, 16'd1);
    step(1, 0, 1, 0, 16'h0001, 16'h0002, 16'd0);
    step(1, 1, 1, 0, 16'h0001, 16'h000E, 16'd0);
    check("tp6_a", longint'(out0), 16'h0005);
    idle(1);
    check("tp6_b", longint'(out0), 16'hFFFE);
    idle(1);

    // Random beats with bubbles, aborts and unframed accumulation.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
      if (i == 200) do_reset();
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
